// File: rtl/fpga_carry_serial_adder.sv
// Bit-serial add/subtract sequencer built around one carry-chain cell
// (carry_out = majority(i0, i1, carry_in)) and a carry flip-flop. One operand
// bit is processed per clock, LSB first.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset
//   start_i - request an operation (accepted only when idle)
//   sub_i   - 0: a + b + cin, 1: a - b (sampled with start_i)
//   a_i     - operand A (sampled with start_i)
//   b_i     - operand B (sampled with start_i)
//   cin_i   - carry-in for add, ignored for subtract
//   busy_o  - high for the WIDTH cycles in which bits are processed
//   done_o  - one-cycle completion pulse, results valid in the same cycle
//   sum_o   - registered result, modulo 2^WIDTH
//   cout_o  - carry out of the MSB (subtract: 1 means no borrow)
//   ovf_o   - signed overflow (carry into MSB xor carry out of MSB)
module fpga_carry_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Counter value at the edge that enters the MSB cycle.
  localparam logic [CntW-1:0] CntPreMsb = CntW'(WIDTH - 2);

  // StRun processes bits 0..WIDTH-2; StDone processes the MSB and commits on
  // its exit edge, so done_o appears in the first idle cycle and a held
  // start_i is accepted one edge later.
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             carry_q;
  logic [CntW-1:0]  cnt_q;

  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] res_next;

  // Carry cell: i0 = a_sh[0], i1 = b_sh[0], carry_in = carry_q.
  always_comb begin
    carry_out = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    sum_bit   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    res_next  = {sum_bit, res_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      sum_o    <= '0;
      cout_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_sh_q  <= a_i;
            // Subtract as a + ~b + 1.
            b_sh_q  <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i | cin_i;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun, StDone: begin
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          res_sh_q <= res_next;
          carry_q  <= carry_out;
          cnt_q    <= cnt_q + CntW'(1);
          if (state_q == StRun) begin
            if (cnt_q == CntPreMsb) begin
              state_q <= StDone;
            end
          end else begin
            // MSB cycle: carry_q still holds the carry into the MSB.
            sum_o   <= res_next;
            cout_o  <= carry_out;
            ovf_o   <= carry_q ^ carry_out;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_carry_serial_adder.sv
// Directed bench for fpga_carry_serial_adder (WIDTH = 8).
module tb_fpga_carry_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  fpga_carry_serial_adder #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .sub_i   (sub),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
    .busy_o  (busy),
    .done_o  (done),
    .sum_o   (sum),
    .cout_o  (cout),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] es, input logic ec,
                            input logic eo);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
  endtask

  // Issue one operation and check the full busy/done timeline and the result.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic tc, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    step();                       // edge T0
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " no done"}, 32'(done), 32'd0);
      step();
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy low"}, 32'(busy), 32'd0);
    check_outs(tag, es, ec, eo);
    step();
    check({tag, " done pulse"}, 32'(done), 32'd0);
    check_outs({tag, " hold"}, es, ec, eo);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    // Reset held for 3 cycles with random inputs.
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      a = W'($urandom); b = W'($urandom);
      step();
    end
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check_outs("rst", 8'h00, 1'b0, 1'b0);
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle busy", 32'(busy), 32'd0);
    end

    run_op("add", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    run_op("add wrap", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    run_op("sub", 8'h10, 8'h20, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    run_op("sub ovf", 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1);

    // start_i held high; operands change during the run.
    a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();                       // T0
    a = 8'hAA; b = 8'h55;
    for (int i = 0; i < int'(W); i++) begin
      check("held busy", 32'(busy), 32'd1);
      check("held no done", 32'(done), 32'd0);
      step();
    end
    check("held done", 32'(done), 32'd1);
    check_outs("held first", 8'h03, 1'b0, 1'b0);
    step();                       // T0+9: second acceptance
    check("held reaccept busy", 32'(busy), 32'd1);
    check("held reaccept done", 32'(done), 32'd0);
    start = 1'b0;
    for (int i = 0; i < int'(W) - 1; i++) begin
      step();
      check("held sum hold", 32'(sum), 32'h03);
      check("held busy2", 32'(busy), 32'd1);
    end
    step();                       // T0+17
    check("held done2", 32'(done), 32'd1);
    check_outs("held second", 8'hFF, 1'b0, 1'b0);
    step();

    // Reset asserted in the 4th RUN cycle.
    a = 8'h12; b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();                       // T0
    start = 1'b0;
    step();
    step();
    step();                       // inside 4th RUN cycle
    rst_n = 1'b0;
    step();
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check_outs("abort", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort no done", 32'(done), 32'd0);
    end
    run_op("after abort", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
